// File: rtl/squeeze_bias_sequencer_pkg.sv
// Shared types and helpers for the fire squeeze-layer bias sequencer.
// Biases are stored sign-magnitude and converted to two's complement before the add.
package squeeze_pkg;

  localparam int unsigned N_CH  = 32;
  localparam int unsigned N_PIX = 729;
  localparam logic [15:0] SM_MAX = 16'h7FFF;

  typedef struct packed {
    logic        sign;
    logic [14:0] mag;
  } sm16_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } seq_state_t;

  // Negating a zero magnitude yields zero, so 0x8000 (negative zero) maps to 0.
  // Result is sign-extended from w bits so callers may slice any width up to w.
  function automatic logic signed [63:0] sm_to_tc(sm16_t v, int w);
    logic signed [63:0] mag;
    logic signed [63:0] r;
    mag = 64'(v.mag);
    r   = v.sign ? -mag : mag;
    return (r <<< (64 - w)) >>> (64 - w);
  endfunction

endpackage

// File: rtl/squeeze_bias_sequencer_bias_relu_sat.sv
// Two-stage bias-add / ReLU / saturate pipeline with valid-ready flow control.
// Channel tag and last flag travel alongside the data.
module bias_relu_sat
  import squeeze_pkg::*;
#(
  parameter int unsigned AccW = 32,
  parameter int unsigned ChW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_fire,
  input  logic [AccW-1:0] in_acc,
  input  logic [15:0]     bias,
  input  logic [ChW-1:0]  in_ch,
  input  logic            in_last,
  output logic            s1_adv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic [ChW-1:0]  out_ch,
  output logic            out_last
);

  logic               s2_adv;
  logic signed [63:0] bias_tc;

  logic            s1_v_q, s1_v_d;
  logic [AccW:0]   s1_sum_q, s1_sum_d;
  logic [ChW-1:0]  s1_ch_q, s1_ch_d;
  logic            s1_last_q, s1_last_d;

  logic            s2_v_q, s2_v_d;
  logic [14:0]     s2_res_q, s2_res_d;
  logic [ChW-1:0]  s2_ch_q, s2_ch_d;
  logic            s2_last_q, s2_last_d;

  always_comb begin
    s2_adv  = !s2_v_q | out_ready;
    s1_adv  = !s1_v_q | s2_adv;
    bias_tc = sm_to_tc(sm16_t'(bias), int'(AccW) + 1);

    s1_v_d    = s1_v_q;
    s1_sum_d  = s1_sum_q;
    s1_ch_d   = s1_ch_q;
    s1_last_d = s1_last_q;
    if (s1_adv) begin
      s1_v_d = in_fire;
      if (in_fire) begin
        // One extra bit of headroom: the sum of a full-range acc and a 16-bit bias cannot wrap.
        s1_sum_d  = {in_acc[AccW-1], in_acc} + bias_tc[AccW:0];
        s1_ch_d   = in_ch;
        s1_last_d = in_last;
      end
    end

    s2_v_d    = s2_v_q;
    s2_res_d  = s2_res_q;
    s2_ch_d   = s2_ch_q;
    s2_last_d = s2_last_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        if (s1_sum_q[AccW]) begin
          s2_res_d = '0;
        end else if (|s1_sum_q[AccW-1:15]) begin
          s2_res_d = SM_MAX[14:0];
        end else begin
          s2_res_d = s1_sum_q[14:0];
        end
        s2_ch_d   = s1_ch_q;
        s2_last_d = s1_last_q;
      end
    end

    out_valid = s2_v_q;
    out_data  = {1'b0, s2_res_q};
    out_ch    = s2_ch_q;
    out_last  = s2_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_sum_q  <= '0;
      s1_ch_q   <= '0;
      s1_last_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_res_q  <= '0;
      s2_ch_q   <= '0;
      s2_last_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sum_q  <= s1_sum_d;
      s1_ch_q   <= s1_ch_d;
      s1_last_q <= s1_last_d;
      s2_v_q    <= s2_v_d;
      s2_res_q  <= s2_res_d;
      s2_ch_q   <= s2_ch_d;
      s2_last_q <= s2_last_d;
    end
  end

endmodule

// File: rtl/squeeze_bias_sequencer.sv
// Frame sequencer for the fire squeeze layer: counts channels/pixels, selects the
// channel bias and feeds the bias/ReLU/saturate pipeline.
module squeeze_bias_sequencer
  import squeeze_pkg::*;
#(
  parameter int unsigned NCh   = N_CH,
  parameter int unsigned NPix  = N_PIX,
  parameter int unsigned BiasW = 16,
  parameter int unsigned AccW  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [NCh*BiasW-1:0]    bias_mem,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AccW-1:0]         in_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BiasW-1:0]        out_data,
  output logic [$clog2(NCh)-1:0]  out_ch,
  output logic                    out_last
);

  localparam int unsigned ChW  = $clog2(NCh);
  localparam int unsigned PixW = (NPix > 1) ? $clog2(NPix) : 1;

  seq_state_t      state_q, state_d;
  logic [ChW-1:0]  ch_cnt_q, ch_cnt_d;
  logic [PixW-1:0] pix_cnt_q, pix_cnt_d;

  logic             s1_adv;
  logic             in_fire;
  logic             ch_wrap;
  logic             in_is_last;
  logic [BiasW-1:0] bias_sel;

  always_comb begin
    in_ready   = (state_q == StRun) & s1_adv;
    in_fire    = in_valid & in_ready;
    ch_wrap    = (ch_cnt_q == ChW'(NCh - 1));
    in_is_last = ch_wrap & (pix_cnt_q == PixW'(NPix - 1));
    bias_sel   = bias_mem[int'(ch_cnt_q) * BiasW +: BiasW];

    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
        end
      end
      StRun: begin
        // Counters park on the final channel/pixel while the pipeline drains.
        if (in_fire) begin
          if (in_is_last) begin
            state_d = StDrain;
          end else if (ch_wrap) begin
            ch_cnt_d  = '0;
            pix_cnt_d = pix_cnt_q + 1'b1;
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_valid & out_ready & out_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy = (state_q == StRun) | (state_q == StDrain);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  bias_relu_sat #(
    .AccW (AccW),
    .ChW  (ChW)
  ) u_bias_relu_sat (
    .clk       (clk),
    .rst       (rst),
    .in_fire   (in_fire),
    .in_acc    (in_acc),
    .bias      (bias_sel),
    .in_ch     (ch_cnt_q),
    .in_last   (in_is_last),
    .s1_adv    (s1_adv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_squeeze_bias_sequencer.sv
// Randomized self-checking bench for squeeze_bias_sequencer with a 2-pixel frame.
// Expected outputs come from an arithmetic reference model and an ordered scoreboard.
module tb_squeeze_bias_sequencer;

  localparam int NCH  = 32;
  localparam int NPIX = 2;
  localparam int NOUT = NCH * NPIX;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [NCH*16-1:0] bias_mem;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_acc;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [4:0]        out_ch;
  logic              out_last;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  ch;
    logic        last;
  } exp_t;

  logic [15:0] bias [NCH];
  exp_t        exp_q [$];
  logic [15:0] got_data [NOUT];
  logic [4:0]  got_ch [NOUT];
  logic        got_last [NOUT];

  int n_cmp = 0;
  int n_fail = 0;
  int acc_idx = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -1;
  int cyc = 0;

  squeeze_bias_sequencer #(
    .NCh  (NCH),
    .NPix (NPIX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bias_mem  (bias_mem),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: signed acc plus signed bias, clamped to [0, 32767].
  function automatic logic [15:0] ref_out(logic [31:0] acc, logic [15:0] b);
    longint bv = longint'(b[14:0]);
    longint s  = longint'($signed(acc)) + (b[15] ? -bv : bv);
    if (s < 0) return 16'h0000;
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  function automatic void model_accept(logic [31:0] acc);
    exp_t e;
    e.ch   = 5'(acc_idx % NCH);
    e.data = ref_out(acc, bias[acc_idx % NCH]);
    e.last = (acc_idx == NOUT - 1);
    exp_q.push_back(e);
    acc_idx++;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%h ch=%0d, none expected", out_data, out_ch);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({out_data, out_ch, out_last} !== {e.data, e.ch, e.last}) begin
          n_fail++;
          $display("FAIL stream_item: got data=%h ch=%0d last=%b, want data=%h ch=%0d last=%b",
                   out_data, out_ch, out_last, e.data, e.ch, e.last);
        end
      end
      if (out_cnt < NOUT) begin
        got_data[out_cnt] = out_data;
        got_ch[out_cnt]   = out_ch;
        got_last[out_cnt] = out_last;
      end
      out_cnt++;
      if (out_last) last_cyc = cyc;
    end
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    acc_idx = 0;
    out_cnt = 0;
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds in_valid until accepted; ok = 0 if the handshake never happened.
  task automatic send(input logic [31:0] acc, output bit ok);
    in_valid = 1'b1;
    in_acc   = acc;
    ok       = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(acc);
        ok = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_acc();
    return 32'($urandom_range(0, 80000)) - 32'd40000;
  endfunction

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid, in_ready, out_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/ov/ir/last=%b want 00000",
               {busy, done, out_valid, in_ready, out_last});
    end
    n_cmp++;
    if (out_data !== 16'h0 || out_ch !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_out: data=%h ch=%0d want 0000/0", out_data, out_ch);
    end
    tick();
    in_valid = 1'b1;
    in_acc   = 32'd123;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_input: in_ready=%b busy=%b want 0 0", in_ready, busy);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_vectors;
    logic [31:0] accs [NOUT];
    bit ok;
    int to = 0;
    for (int i = 0; i < NOUT; i++) accs[i] = rand_acc();
    accs[0]  = 32'd100;
    accs[5]  = 32'd7;
    accs[12] = 32'hFFFF_FFFB;
    accs[13] = 32'h0001_0000;
    accs[32] = 32'd10;
    accs[45] = 32'h8000_0000;
    do_start();
    send(accs[0], ok);
    if (!ok) to++;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, want 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h0036 || out_ch !== 5'd0) begin
      n_fail++;
      $display("FAIL latency_2: ov=%b data=%h ch=%0d want 1 0036 0", out_valid, out_data, out_ch);
    end
    tick();
    for (int i = 1; i < NOUT; i++) begin
      send(accs[i], ok);
      if (!ok) to++;
    end
    for (int c = 0; c < 200 && out_cnt < NOUT; c++) tick();
    repeat (3) tick();
    n_cmp++;
    if (to != 0 || out_cnt != NOUT) begin
      n_fail++;
      $display("FAIL vec_count: outputs=%0d timeouts=%0d want %0d 0", out_cnt, to, NOUT);
    end
    n_cmp++;
    if (got_data[5] !== 16'h0007) begin
      n_fail++;
      $display("FAIL neg_zero_bias: got %h want 0007", got_data[5]);
    end
    n_cmp++;
    if (got_data[12] !== 16'h0000 || got_data[32] !== 16'h0000) begin
      n_fail++;
      $display("FAIL relu: got %h %h want 0000 0000", got_data[12], got_data[32]);
    end
    n_cmp++;
    if (got_data[13] !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL saturate: got %h want 7fff", got_data[13]);
    end
    n_cmp++;
    if (got_data[45] !== 16'h0000) begin
      n_fail++;
      $display("FAIL min_acc: got %h want 0000", got_data[45]);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] pend;
    logic [15:0] held;
    bit ok;
    int to = 0;
    int bad_ch = 0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      send(rand_acc(), ok);
      if (!ok) to++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    pend      = rand_acc();
    in_acc    = pend;
    held      = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) held = out_data;
      if (c == 5) begin
        n_cmp++;
        if (in_ready !== 1'b0 || (acc_idx - out_cnt) != 2) begin
          n_fail++;
          $display("FAIL stall_inflight: in_ready=%b inflight=%0d want 0 2",
                   in_ready, acc_idx - out_cnt);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold: ov=%b data=%h want 1 %h", out_valid, out_data, held);
        end
      end
      if (in_ready) begin
        model_accept(pend);
        pend = rand_acc();
      end
      tick();
      in_acc = pend;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (acc_idx < NOUT && to < 4) begin
      send(rand_acc(), ok);
      if (!ok) to++;
    end
    for (int c = 0; c < 200 && out_cnt < NOUT; c++) tick();
    repeat (3) tick();
    for (int i = 0; i < NOUT; i++) if (got_ch[i] !== 5'(i % NCH)) bad_ch++;
    n_cmp++;
    if (to != 0 || out_cnt != NOUT || bad_ch != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_order: outputs=%0d bad_ch=%0d left=%0d to=%0d want %0d 0 0 0",
               out_cnt, bad_ch, exp_q.size(), to, NOUT);
    end
  endtask

  task automatic test_frame;
    bit ok;
    int to = 0;
    int d0;
    int n_last = 0;
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < NOUT; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == 20) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send(rand_acc(), ok);
      if (!ok) to++;
    end
    for (int c = 0; c < 200 && out_cnt < NOUT; c++) tick();
    repeat (3) tick();
    for (int i = 0; i < NOUT; i++) if (got_last[i] === 1'b1) n_last++;
    n_cmp++;
    if (to != 0 || out_cnt != NOUT || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_count: outputs=%0d left=%0d to=%0d want %0d 0 0",
               out_cnt, exp_q.size(), to, NOUT);
    end
    n_cmp++;
    if (n_last != 1 || got_last[NOUT-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_last: last_count=%0d last_on_final=%b want 1 1",
               n_last, got_last[NOUT-1]);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || done_cyc != last_cyc + 1) begin
      n_fail++;
      $display("FAIL done_pulse: pulses=%0d done_cyc=%0d last_cyc=%0d want 1, last+1",
               done_cnt - d0, done_cyc, last_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_done: busy=%b done=%b want 0 0", busy, done);
    end
    tick();
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int to = 0;
    int d0;
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 10; i++) begin
      send(rand_acc(), ok);
      if (!ok) to++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_idx = 0;
    out_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done, in_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL midframe_rst: ov/busy/done/ir=%b want 0000",
               {out_valid, busy, done, in_ready});
    end
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != d0 || out_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: done_pulses=%0d outputs=%0d want 0 0", done_cnt - d0, out_cnt);
    end
    do_start();
    for (int i = 0; i < NOUT; i++) begin
      send(rand_acc(), ok);
      if (!ok) to++;
    end
    for (int c = 0; c < 200 && out_cnt < NOUT; c++) tick();
    repeat (3) tick();
    n_cmp++;
    if (to != 0 || out_cnt != NOUT || got_ch[0] !== 5'd0 || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL restart: outputs=%0d first_ch=%0d dones=%0d to=%0d want %0d 0 1 0",
               out_cnt, got_ch[0], done_cnt - d0, to, NOUT);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) bias[i] = 16'($urandom);
    bias[0]  = 16'h802E;
    bias[5]  = 16'h8000;
    bias[12] = 16'h82A1;
    bias[13] = 16'h0280;
    for (int i = 0; i < NCH; i++) bias_mem[i*16 +: 16] = bias[i];
    for (int i = 0; i < NOUT; i++) begin
      got_data[i] = '0;
      got_ch[i]   = '0;
      got_last[i] = 1'b0;
    end

    test_reset();
    test_vectors();
    test_backpressure();
    test_frame();
    test_reset_midframe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
